// File: rtl/ecdsa_pkg.sv
// Shared types and constants for the ECDSA modular-arithmetic blocks.
// Holds the operand width, the multiplier radix and the sequencer state encodings.
package ecdsa_pkg;

  localparam int W    = 256;
  localparam int MM_V = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_TOM,
    S_SQR,
    S_MUL,
    S_FROMM,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    P_IDLE,
    P_STB,
    P_GAP,
    P_WAIT
  } phase_e;

endpackage

// File: rtl/mm_issue.sv
// Issues one Montgomery-multiplier op: registers operands, pulses the load strobe,
// waits for mm_done and flags op_done. Ports: go/op_a/op_b in, mm_rst_n/mm_a/mm_b out.
module mm_issue
  import ecdsa_pkg::*;
#(
  parameter int OW = 256
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          go,
  input  logic [OW-1:0] op_a,
  input  logic [OW-1:0] op_b,
  input  logic          mm_done,
  output logic          mm_rst_n,
  output logic [OW-1:0] mm_a,
  output logic [OW-1:0] mm_b,
  output logic          op_done
);

  phase_e        ph_q, ph_d;
  logic          rst_n_q, rst_n_d;
  logic [OW-1:0] a_q, a_d;
  logic [OW-1:0] b_q, b_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph_q    <= P_IDLE;
      rst_n_q <= 1'b1;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      ph_q    <= ph_d;
      rst_n_q <= rst_n_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  // mm_done is stale during the strobe cycle and the cycle after it,
  // so it is only honoured once we reach P_WAIT.
  always_comb begin
    ph_d    = ph_q;
    rst_n_d = 1'b1;
    a_d     = a_q;
    b_d     = b_q;
    op_done = 1'b0;
    unique case (ph_q)
      P_STB:  ph_d = P_GAP;
      P_GAP:  ph_d = P_WAIT;
      P_WAIT: begin
        if (mm_done) begin
          op_done = 1'b1;
          ph_d    = P_IDLE;
        end
      end
      default: ph_d = ph_q;
    endcase
    if (go) begin
      a_d     = op_a;
      b_d     = op_b;
      rst_n_d = 1'b0;
      ph_d    = P_STB;
    end
  end

  assign mm_rst_n = rst_n_q;
  assign mm_a     = a_q;
  assign mm_b     = b_q;

endmodule

// File: rtl/mont_modexp_ctrl.sv
// Left-to-right square-and-multiply sequencer driving one external Montgomery multiplier.
// Inputs: start/base/exp/n/s/k/r_mod_n/r2_mod_n, mm_c/mm_done. Outputs: busy/done/result, mm_*.
module mont_modexp_ctrl
  import ecdsa_pkg::*;
#(
  parameter int EW = 256,
  parameter int W  = ecdsa_pkg::W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [W-1:0]  base,
  input  logic [EW-1:0] exp,
  input  logic [W-1:0]  n,
  input  logic [W-1:0]  s,
  input  logic [7:0]    k,
  input  logic [W-1:0]  r_mod_n,
  input  logic [W-1:0]  r2_mod_n,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  result,
  output logic          mm_rst_n,
  output logic [W-1:0]  mm_a,
  output logic [W-1:0]  mm_b,
  output logic [W-1:0]  mm_n,
  output logic [W-1:0]  mm_s,
  output logic [7:0]    mm_k,
  input  logic [W-1:0]  mm_c,
  input  logic          mm_done
);

  localparam int CW = (EW > 1) ? $clog2(EW) : 1;

  state_e         state_q, state_d;
  logic           busy_q, busy_d;
  logic [W-1:0]   result_q, result_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   bm_q, bm_d;
  logic [EW-1:0]  exp_sh_q, exp_sh_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   n_q, n_d;
  logic [W-1:0]   s_q, s_d;
  logic [7:0]     k_q, k_d;

  logic           go;
  logic           adv;
  logic           op_done;
  logic [W-1:0]   op_a;
  logic [W-1:0]   op_b;

  mm_issue #(.OW(W)) u_issue (
    .clk      (clk),
    .reset    (reset),
    .go       (go),
    .op_a     (op_a),
    .op_b     (op_b),
    .mm_done  (mm_done),
    .mm_rst_n (mm_rst_n),
    .mm_a     (mm_a),
    .mm_b     (mm_b),
    .op_done  (op_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      result_q <= '0;
      acc_q    <= '0;
      bm_q     <= '0;
      exp_sh_q <= '0;
      cnt_q    <= '0;
      n_q      <= '0;
      s_q      <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      result_q <= result_d;
      acc_q    <= acc_d;
      bm_q     <= bm_d;
      exp_sh_q <= exp_sh_d;
      cnt_q    <= cnt_d;
      n_q      <= n_d;
      s_q      <= s_d;
      k_q      <= k_d;
    end
  end

  // The next op is issued in the same cycle the previous one completes,
  // so its operands come straight from mm_c rather than from acc_q.
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    result_d = result_q;
    acc_d    = acc_q;
    bm_d     = bm_q;
    exp_sh_d = exp_sh_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    s_d      = s_q;
    k_d      = k_q;
    go       = 1'b0;
    adv      = 1'b0;
    op_a     = acc_q;
    op_b     = acc_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          busy_d   = 1'b1;
          acc_d    = r_mod_n;
          exp_sh_d = exp;
          cnt_d    = CW'(EW - 1);
          n_d      = n;
          s_d      = s;
          k_d      = k;
          go       = 1'b1;
          op_a     = base;
          op_b     = r2_mod_n;
          state_d  = S_TOM;
        end
      end
      S_TOM: begin
        if (op_done) begin
          bm_d    = mm_c;
          go      = 1'b1;
          state_d = S_SQR;
        end
      end
      S_SQR: begin
        if (op_done) begin
          acc_d = mm_c;
          if (exp_sh_q[EW-1]) begin
            go      = 1'b1;
            op_a    = mm_c;
            op_b    = bm_q;
            state_d = S_MUL;
          end else begin
            adv = 1'b1;
          end
        end
      end
      S_MUL: begin
        if (op_done) begin
          acc_d = mm_c;
          adv   = 1'b1;
        end
      end
      S_FROMM: begin
        if (op_done) begin
          result_d = mm_c;
          busy_d   = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Current exponent bit finished: move to next bit or leave Montgomery form.
    if (adv) begin
      go       = 1'b1;
      op_a     = mm_c;
      exp_sh_d = exp_sh_q << 1;
      cnt_d    = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        op_b    = W'(1);
        state_d = S_FROMM;
      end else begin
        op_b    = mm_c;
        state_d = S_SQR;
      end
    end
  end

  assign busy   = busy_q;
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign mm_n   = n_q;
  assign mm_s   = s_q;
  assign mm_k   = k_q;

endmodule

// File: tb/tb_mont_modexp_ctrl.sv
// Scoreboard bench for mont_modexp_ctrl with a behavioural Montgomery multiplier.
// Directed cases on n=13 plus randomized runs against a software modpow.
module tb_mont_modexp_ctrl;

  localparam int W  = 16;
  localparam int EW = 8;

  logic          clk = 0;
  logic          reset = 0;
  logic          start = 0;
  logic [W-1:0]  base = 0;
  logic [EW-1:0] exp = 0;
  logic [W-1:0]  n = 13;
  logic [W-1:0]  s = 0;
  logic [7:0]    k = 8'd1;
  logic [W-1:0]  r_mod_n = 0;
  logic [W-1:0]  r2_mod_n = 0;
  logic          busy, done, mm_rst_n, mm_done;
  logic [W-1:0]  result, mm_a, mm_b, mm_n, mm_s, mm_c;
  logic [7:0]    mm_k;

  mont_modexp_ctrl #(.EW(EW), .W(W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .base(base), .exp(exp), .n(n), .s(s), .k(k),
    .r_mod_n(r_mod_n), .r2_mod_n(r2_mod_n),
    .busy(busy), .done(done), .result(result),
    .mm_rst_n(mm_rst_n), .mm_a(mm_a), .mm_b(mm_b),
    .mm_n(mm_n), .mm_s(mm_s), .mm_k(mm_k),
    .mm_c(mm_c), .mm_done(mm_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    int           ops;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;
  int strobes = 0;
  int dones = 0;
  logic prev_done = 0;
  logic [W-1:0] cur_n = 0;
  logic [W-1:0] cur_s = 0;

  // Montgomery product with R = 2^16 (k=1, v=16): c*R == a*b (mod n).
  function automatic logic [W-1:0] mont(input logic [W-1:0] a,
                                        input logic [W-1:0] b,
                                        input logic [W-1:0] nn);
    longint p;
    p = (longint'(a) * longint'(b)) % longint'(nn);
    for (int c = 0; c < int'(nn); c++)
      if ((longint'(c) * 65536) % longint'(nn) == p) return W'(c);
    return '0;
  endfunction

  function automatic logic [W-1:0] modpow(input int b, input int e,
                                          input int nn);
    longint r;
    r = 1 % nn;
    for (int i = 0; i < e; i++) r = (r * b) % nn;
    return W'(r);
  endfunction

  function automatic logic [W-1:0] neg_inv(input logic [W-1:0] nn);
    logic [W-1:0] inv;
    inv = nn;
    for (int i = 0; i < 5; i++) inv = inv * (W'(2) - nn * inv);
    return -inv;
  endfunction

  // Behavioural multiplier: loads on the active-low strobe, answers after 1..4 cycles.
  logic [W-1:0] ma, mb;
  int mcnt;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mm_done <= 1'b0;
      mm_c    <= '0;
      mcnt    <= 0;
    end else if (!mm_rst_n) begin
      ma      <= mm_a;
      mb      <= mm_b;
      mm_done <= 1'b0;
      mcnt    <= $urandom_range(1, 4);
    end else if (mcnt > 0) begin
      mcnt <= mcnt - 1;
      if (mcnt == 1) begin
        mm_done <= 1'b1;
        mm_c    <= mont(ma, mb, mm_n);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      strobes   = 0;
      prev_done = 0;
    end else begin
      if (!mm_rst_n) begin
        strobes++;
        checks++;
        if (mm_n !== cur_n || mm_s !== cur_s || mm_k !== 8'd1) begin
          failures++;
          $display("FAIL mm_cfg n=%0d s=%h k=%0d want n=%0d s=%h k=1",
                   mm_n, mm_s, mm_k, cur_n, cur_s);
        end
      end
      if (prev_done) begin
        checks++;
        if (done !== 1'b0) begin
          failures++;
          $display("FAIL done_width done still 1, want 0");
        end
      end
      if (done) begin
        dones++;
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL busy_at_done busy=%b want 0", busy);
        end
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL extra_done result=%0d want no done", result);
        end else begin
          e = sb.pop_front();
          checks++;
          if (result !== e.res) begin
            failures++;
            $display("FAIL result got=%0d want=%0d", result, e.res);
          end
          checks++;
          if (strobes != e.ops) begin
            failures++;
            $display("FAIL op_count got=%0d want=%0d", strobes, e.ops);
          end
        end
        strobes = 0;
      end
      prev_done = done;
    end
  end

  task automatic setup(input int b, input int e, input int nn);
    int rm;
    rm       = 65536 % nn;
    base     = W'(b);
    exp      = EW'(e);
    n        = W'(nn);
    s        = neg_inv(W'(nn));
    r_mod_n  = W'(rm);
    r2_mod_n = W'((rm * rm) % nn);
    cur_n    = n;
    cur_s    = s;
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1;
    @(negedge clk) start = 0;
  endtask

  task automatic wait_done(input int d0);
    int t;
    t = 0;
    while (dones == d0 && t < 4000) begin
      @(negedge clk);
      t++;
    end
    if (dones == d0) begin
      checks++;
      failures++;
      $display("FAIL timeout no done after %0d cycles", t);
      sb.delete();
    end
  endtask

  task automatic run(input int b, input int e, input int nn);
    exp_t x;
    int d0;
    setup(b, e, nn);
    x.res = modpow(b, e, nn);
    x.ops = 2 + EW + $countones(EW'(e));
    sb.push_back(x);
    d0 = dones;
    pulse_start();
    wait_done(d0);
  endtask

  task automatic chk(input string nm, input logic [W-1:0] got,
                     input logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", nm, got, want);
    end
  endtask

  initial begin
    exp_t x;
    int d0, t, nn;
    #12;
    chk("rst_busy", W'(busy), 0);
    chk("rst_done", W'(done), 0);
    chk("rst_result", result, 0);
    chk("rst_mm_rst_n", W'(mm_rst_n), 1);
    chk("rst_mm_a", mm_a, 0);
    chk("rst_mm_b", mm_b, 0);
    @(negedge clk) reset = 1;
    repeat (2) @(negedge clk);

    run(2, 5, 13);
    run(2, 11, 13);
    run(5, 0, 13);
    run(0, 3, 13);
    run(12, 255, 13);

    // second start while busy must be ignored
    setup(2, 5, 13);
    x.res = 6;
    x.ops = 12;
    sb.push_back(x);
    d0 = dones;
    pulse_start();
    repeat (4) @(negedge clk);
    base  = 7;
    exp   = 8'd3;
    start = 1;
    @(negedge clk) start = 0;
    base  = 2;
    exp   = 8'd5;
    wait_done(d0);
    repeat (60) @(negedge clk);
    chk("single_done", W'(dones - d0), 1);

    // reset in the middle of the first squaring
    setup(2, 5, 13);
    pulse_start();
    t = 0;
    while (strobes < 2 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("reached_sqr", W'(strobes >= 2), 1);
    reset = 0;
    @(posedge clk);
    #1;
    chk("abort_busy", W'(busy), 0);
    chk("abort_done", W'(done), 0);
    chk("abort_mm_rst_n", W'(mm_rst_n), 1);
    chk("abort_result", result, 0);
    @(negedge clk) reset = 1;
    repeat (2) @(negedge clk);
    run(2, 11, 13);

    for (int i = 0; i < 200; i++) begin
      nn = 2 * $urandom_range(1, 127) + 1;
      run($urandom_range(0, nn - 1), $urandom_range(0, 255), nn);
    end

    repeat (10) @(negedge clk);
    chk("sb_empty", W'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
